// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Issues one word-aligned request per
//            cycle to an instruction memory with a fixed one-cycle read
//            latency, buffers returned words together with their PCs in a
//            small FIFO, and presents the head entry to decode through a
//            valid/ready handshake. Redirects flush everything in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(4);
    localparam logic [CNT_W:0]        c_depth    = (CNT_W + 1)'(BUF_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Fetch PC: address of the next request to issue.
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // One-deep record of the request issued last cycle; its response is on
    // imem_rdata this cycle.
    logic                  inflight_q;
    logic                  inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_d;

    // Instruction buffer bookkeeping.
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;

    // Instruction buffer storage; each word travels with its own PC.
    logic [31:0]           buf_word_q [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                  w_push;
    logic                  w_pop;
    logic                  w_req;
    logic                  w_head_valid;
    logic [CNT_W:0]        w_occ_after_pop;
    logic [ADDR_WIDTH-1:0] w_redirect_aligned;
    logic                  unused_redirect_lsbs;

    // The low two redirect bits are dropped: fetch is always word aligned.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign w_redirect_aligned   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // A redirect hides the head entry in the same cycle, so decode can never
    // consume a wrong-path instruction while the flush is happening.
    assign w_head_valid = (count_q != '0) && !redirect_valid;
    assign w_pop        = w_head_valid && instr_ready;

    // The response to last cycle's request lands in the buffer unless a
    // redirect discards it.
    assign w_push = inflight_q && !redirect_valid;

    // Slots that will be taken once this cycle's pop and the pending
    // response are accounted for; a new request is only issued if its
    // response is guaranteed a free slot next cycle.
    assign w_occ_after_pop = {1'b0, count_q}
                           + (CNT_W + 1)'(inflight_q)
                           - (CNT_W + 1)'(w_pop);

    assign w_req = reset_n && !redirect_valid && (w_occ_after_pop < c_depth);

    // Next-state computation for PC, in-flight tracking and FIFO pointers.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = w_req;
        inflight_pc_d = pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_valid) begin
            // Redirect wins over everything: flush and restart at target.
            pc_d     = w_redirect_aligned;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (w_req) begin
                pc_d = pc_q + c_pc_step;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    // Control registers: PC, in-flight record, occupancy and pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= c_reset_pc;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Buffer storage: write the returning word and its PC at the tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_word_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else if (w_push) begin
            buf_word_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The head slot is never rewritten while it is occupied, so instr and
    // instr_pc stay stable for as long as decode stalls.
    assign imem_req    = w_req;
    assign imem_addr   = pc_q;
    assign instr_valid = w_head_valid;
    assign instr       = buf_word_q[rd_ptr_q];
    assign instr_pc    = buf_pc_q[rd_ptr_q];

    // ------------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    // Request throttling guarantees a free slot for every response.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!reset_n)
        w_push |-> (count_q < CNT_W'(BUF_DEPTH))
    ) else $error("fetch_unit: push into a full instruction buffer");
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A queue-based reference
//            model predicts the outputs every cycle; directed phases pin the
//            start-up, stall, redirect, wrap and asynchronous reset behaviour
//            with hand-computed values, followed by a long random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (32-bit addresses, RESET_PC = 0)
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // Narrow instance (8-bit addresses, RESET_PC = 0xF8), always ready
    logic        s_req;
    logic [7:0]  s_addr;
    logic [31:0] s_rdata;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [7:0]  s_ipc;

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (0),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    fetch_unit #(
        .ADDR_WIDTH (8),
        .RESET_PC   (32'hF8),
        .BUF_DEPTH  (2)
    ) dut8 (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (s_req),
        .imem_addr      (s_addr),
        .imem_rdata     (s_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .instr_valid    (s_valid),
        .instr_ready    (1'b1),
        .instr          (s_instr),
        .instr_pc       (s_ipc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    int tests = 0;
    int fails = 0;

    // Request seen by the memory model in the cycle that just ended
    logic        cap_req    = 1'b0;
    logic [31:0] cap_addr   = '0;
    logic        s_cap_req  = 1'b0;
    logic [7:0]  s_cap_addr = '0;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc     = RPC;
    logic        m_inf    = 1'b0;
    logic [31:0] m_inf_pc = '0;
    ent_t        s_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: once per cycle, mid-cycle, check against the model
    // and then advance the model across the coming clock edge.
    initial begin : p_compare
        logic e_valid;
        logic e_req;
        logic pop;
        forever begin
            @(negedge clk);
            cap_req    = imem_req;
            cap_addr   = imem_addr;
            s_cap_req  = s_req;
            s_cap_addr = s_addr;
            if (s_valid && reset_n) s_log.push_back('{pc: 32'(s_ipc), w: s_instr});

            if (!reset_n) begin
                m_q.delete();
                m_pc  = RPC;
                m_inf = 1'b0;
                check("rst_req",   64'(imem_req),    64'(0));
                check("rst_valid", 64'(instr_valid), 64'(0));
                check("rst_addr",  64'(imem_addr),   64'(RPC));
                check("rst_instr", 64'(instr),       64'(0));
                check("rst_ipc",   64'(instr_pc),    64'(0));
            end else begin
                e_valid = (m_q.size() != 0) && !redirect_valid;
                pop     = e_valid && instr_ready;
                e_req   = !redirect_valid &&
                          ((m_q.size() + int'(m_inf) - int'(pop)) < int'(DEPTH));
                check("m_req",   64'(imem_req),    64'(e_req));
                check("m_addr",  64'(imem_addr),   64'(m_pc));
                check("m_valid", 64'(instr_valid), 64'(e_valid));
                if (e_valid) begin
                    check("m_instr_pc", 64'(instr_pc), 64'(m_q[0].pc));
                    check("m_instr",    64'(instr),    64'(m_q[0].w));
                end
                if (redirect_valid) begin
                    m_q.delete();
                    m_inf = 1'b0;
                    m_pc  = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (pop) void'(m_q.pop_front());
                    if (m_inf) m_q.push_back('{pc: m_inf_pc, w: imem_rdata});
                    m_inf    = e_req;
                    m_inf_pc = m_pc;
                    if (e_req) m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // One clock cycle of stimulus: memory answers last cycle's request,
    // garbage otherwise.
    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        imem_rdata     = cap_req ? (cap_addr ^ XORK) : $urandom;
        s_rdata        = s_cap_req ? ({24'h0, s_cap_addr} ^ XORK) : $urandom;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    initial begin : p_stim
        logic rdy;
        logic rd;
        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        s_rdata        = '0;
        repeat (3) cyc(1'b0, 1'b0, 32'h0);

        // Reset release: first request in E0, first instruction at E0+2
        cyc(1'b1, 1'b0, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("e0_req",   64'(imem_req),    64'(1));
        check("e0_addr",  64'(imem_addr),   64'(0));
        check("e0_valid", 64'(instr_valid), 64'(0));
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("e1_valid", 64'(instr_valid), 64'(0));
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            @(negedge clk);
            check("stream_valid", 64'(instr_valid), 64'(1));
            check("stream_pc",    64'(instr_pc),    64'(32'(4 * i)));
            check("stream_instr", 64'(instr),       64'(32'(4 * i) ^ XORK));
        end

        // Decode stall: head holds at 0x20, fetch stops once the buffer fills
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("stall_valid", 64'(instr_valid), 64'(1));
            check("stall_pc",    64'(instr_pc),    64'(32'h20));
            check("stall_instr", 64'(instr),       64'(32'h20 ^ XORK));
        end
        check("stall_req", 64'(imem_req), 64'(0));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            @(negedge clk);
            check("resume_valid", 64'(instr_valid), 64'(1));
            check("resume_pc",    64'(instr_pc),    64'(32'(32'h20 + 4 * i)));
        end

        // Redirect to 0x103 with a response arriving in the same cycle
        cyc(1'b1, 1'b1, 32'h103);
        @(negedge clk);
        check("rd_t_valid", 64'(instr_valid), 64'(0));
        check("rd_t_req",   64'(imem_req),    64'(0));
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rd_t1_req",   64'(imem_req),    64'(1));
        check("rd_t1_addr",  64'(imem_addr),   64'(32'h100));
        check("rd_t1_valid", 64'(instr_valid), 64'(0));
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rd_t2_valid", 64'(instr_valid), 64'(0));
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rd_t3_valid", 64'(instr_valid), 64'(1));
        check("rd_t3_pc",    64'(instr_pc),    64'(32'h100));
        check("rd_t3_instr", 64'(instr),       64'(32'h100 ^ XORK));

        // Back-to-back redirects: the last one wins
        cyc(1'b1, 1'b1, 32'h200);
        cyc(1'b1, 1'b1, 32'h304);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("b2b_t2_valid", 64'(instr_valid), 64'(0));
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("b2b_t3_valid", 64'(instr_valid), 64'(1));
        check("b2b_t3_pc",    64'(instr_pc),    64'(32'h304));

        // Narrow instance wraps modulo 2^8 from 0xF8
        check("w8_count", 64'(s_log.size() >= 4), 64'(1));
        if (s_log.size() >= 4) begin
            check("w8_pc0", 64'(s_log[0].pc), 64'(32'hF8));
            check("w8_pc1", 64'(s_log[1].pc), 64'(32'hFC));
            check("w8_pc2", 64'(s_log[2].pc), 64'(32'h00));
            check("w8_pc3", 64'(s_log[3].pc), 64'(32'h04));
            check("w8_w1",  64'(s_log[1].w),  64'(32'hFC ^ XORK));
        end

        // Asynchronous reset mid-stream, between clock edges
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_req",    64'(imem_req),    64'(0));
        check("ar_valid",  64'(instr_valid), 64'(0));
        check("ar_addr",   64'(imem_addr),   64'(RPC));
        check("ar_instr",  64'(instr),       64'(0));
        check("ar_ipc",    64'(instr_pc),    64'(0));
        check("ar_s_addr", 64'(s_addr),      64'(8'hF8));
        check("ar_s_valid",64'(s_valid),     64'(0));
        repeat (2) cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ar_e0_addr", 64'(imem_addr), 64'(0));
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("ar_e2_valid", 64'(instr_valid), 64'(1));
        check("ar_e2_pc",    64'(instr_pc),    64'(0));
        check("ar_e2_instr", 64'(instr),       64'(XORK));

        // 32-bit wrap via redirect near the top of the address space
        cyc(1'b1, 1'b1, 32'hFFFF_FFF9);
        repeat (6) cyc(1'b1, 1'b0, 32'h0);

        // Random ready / redirect traffic against the model
        for (int i = 0; i < 10000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ((i % 500) < 15) rdy = 1'b0;
            rd  = ($urandom_range(0, 19) == 0);
            cyc(rdy, rd, $urandom);
        end
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
